pairing_host_ctrl: RTL and testbench
====================================

Name: pairing_host_ctrl

Overview:
- Host-side sequencer directly upstream of the `pairing` serial wrapper.
- Converts whole-word host commands (WRITE operand, READ result, RUN program) into `pairing`'s bit-serial protocol: update/ready/i/o shifting, sel/w/addr memory strobes, core reset pulse and done wait.
- One command in flight. Every command produces exactly one response.

Parameters:
- WIDTH, 198, operand/result word width; equals the `pairing` shift-register length.
- ADDR_W, 6, core memory address width.
- READ_WAIT, 2, cycles sel/addr are held (w=0) before update captures `out`; range 1..15.
- TIMEOUT, 1000000, max cycles RUN waits for done before erroring; 20-bit counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 WRITE, 01 READ, 10 RUN, 11 illegal.
- cmd_addr  in  ADDR_W  core memory address (WRITE/READ).
- cmd_data  in  WIDTH  operand (WRITE).
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  host takes response.
- rsp_data  out  WIDTH  READ result; 0 for other ops.
- rsp_err  out  1  1 = illegal op or RUN timeout.
- p_sel  out  1  to pairing sel.
- p_addr  out  ADDR_W  to pairing addr.
- p_w  out  1  to pairing w.
- p_update  out  1  to pairing update.
- p_ready  out  1  to pairing ready.
- p_i  out  1  to pairing i.
- p_core_rst  out  1  to pairing reset (active-high core start).
- p_o  in  1  from pairing o.
- p_done  in  1  from pairing done.

Behaviour:
- Reset values:
  - All outputs 0 except cmd_ready = 1. State IDLE.
  - Async reset mid-command aborts immediately. No response is produced and pairing strobes drop to 0.
- cmd_ready = 1 only in IDLE. cmd_op/addr/data are captured on acceptance, and later changes to the inputs are ignored.
- All p_* outputs are registered. p_sel, p_w, p_update, p_ready, p_core_rst are 0 except in the states named below.
- Bit counter is 8 bits and counts 0..WIDTH-1. Wait counter is 20 bits.
- WRITE (accept at edge T):
  - W_CLR: 1 cycle, p_update = 1.
  - W_SHIFT: WIDTH cycles, p_ready = 1, p_i = data[k] on the k-th cycle (LSB first).
  - W_COMMIT: 1 cycle, p_sel = 1, p_w = 1, p_addr = addr.
  - RESP.
  - rsp_valid rises at T + WIDTH + 3 (201 cycles for WIDTH = 198).
- READ:
  - R_SEL: READ_WAIT cycles, p_sel = 1, p_w = 0, p_addr = addr.
  - R_CAP: 1 cycle, p_sel/p_addr held, p_update = 1.
  - R_SHIFT: WIDTH cycles, p_ready = 1. Each cycle p_o is sampled and shifted in as rsp_data <= {p_o, rsp_data[WIDTH-1:1]}, so the first bit lands in bit 0.
  - RESP, with rsp_err = 0.
- RUN:
  - X_RST: 1 cycle, p_core_rst = 1.
  - X_WAIT: waits until p_done = 1, sampled starting the cycle after X_RST. A stale done during X_RST is ignored.
  - Done seen → RESP with err = 0.
  - Wait counter reaching TIMEOUT → RESP with err = 1.
- Illegal op 11: straight to RESP with err = 1, data = 0. No p_* activity.
- RESP:
  - rsp_valid = 1, and rsp_data/rsp_err are stable.
  - On rsp_valid && rsp_ready → IDLE. cmd_ready is 1 the next cycle.
  - A command is not accepted in the same cycle as the response handshake.
- rsp_data is cleared to 0 at WRITE/RUN acceptance.

Test Plan:
- WRITE addr = 6'h05, data = 198'h1: exactly one p_update pulse; 198 p_ready cycles with p_i = 1 only on the first; one cycle of p_sel = p_w = 1, p_addr = 5; rsp_valid at T+201 with err = 0.
- READ addr = 6'h0A, pairing model returning pattern 198'hA5…A5:
  - p_sel is high for READ_WAIT + 1 = 3 cycles, and p_update is high on the 3rd.
  - 198 p_ready cycles follow.
  - rsp_data equals the pattern exactly.
- WRITE then READ of 198'h3FFF…F (all ones) through a behavioural `pairing`/memory model: rsp_data equals all ones, confirming round-trip bit order.
- RUN with the model raising p_done 500 cycles after p_core_rst: a single p_core_rst pulse; response err = 0, ~502 cycles after accept.
- RUN with p_done stuck 0 (TIMEOUT overridden to 100): response err = 1 after 100 wait cycles.
- Illegal op 11: response next-but-one cycle with err = 1 and no p_* toggles.
- Back-pressure: rsp_ready held 0 for 50 cycles keeps rsp_valid/rsp_data stable and cmd_ready = 0.
- Reset asserted mid-W_SHIFT: all p_* go 0 at once, no response, and a fresh WRITE afterwards completes normally.

Source files
------------

// File: rtl/pairing_host_ctrl.sv
// Host-side sequencer for the bit-serial `pairing` wrapper. Turns whole-word
// WRITE / READ / RUN commands into update/ready/i/o shifting and sel/w strobes.
module pairing_host_ctrl #(
    parameter int WIDTH     = 198,
    parameter int ADDR_W    = 6,
    parameter int READ_WAIT = 2,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [WIDTH-1:0]  cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              p_sel,
    output logic [ADDR_W-1:0] p_addr,
    output logic              p_w,
    output logic              p_update,
    output logic              p_ready,
    output logic              p_i,
    output logic              p_core_rst,
    input  logic              p_o,
    input  logic              p_done,
    output logic [3:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // cmd_ready is high only in IDLE; rsp_valid, once high, holds rsp_data and
    // rsp_err steady until rsp_ready is seen, and valid never depends on ready.

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        W_CLR    = 4'd1,
        W_SHIFT  = 4'd2,
        W_COMMIT = 4'd3,
        R_SEL    = 4'd4,
        R_CAP    = 4'd5,
        R_SHIFT  = 4'd6,
        X_RST    = 4'd7,
        X_WAIT   = 4'd8,
        RESP     = 4'd9
    } state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WIDTH-1:0]    data_q;
    logic [7:0]          bit_cnt;
    logic [19:0]         wait_cnt;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= OP_WRITE;
            addr_q     <= '0;
            data_q     <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            p_sel      <= 1'b0;
            p_addr     <= '0;
            p_w        <= 1'b0;
            p_update   <= 1'b0;
            p_ready    <= 1'b0;
            p_i        <= 1'b0;
            p_core_rst <= 1'b0;
        end else begin
            // Pairing strobes are a registered decode of the state, so they
            // trail the state register by exactly one cycle.
            p_sel      <= (state == W_COMMIT) || (state == R_SEL) || (state == R_CAP);
            p_addr     <= ((state == W_COMMIT) || (state == R_SEL) || (state == R_CAP))
                          ? addr_q : '0;
            p_w        <= (state == W_COMMIT);
            p_update   <= (state == W_CLR) || (state == R_CAP);
            p_ready    <= (state == W_SHIFT) || (state == R_SHIFT);
            p_i        <= (state == W_SHIFT) ? data_q[bit_cnt] : 1'b0;
            p_core_rst <= (state == X_RST);

            // Read data is sampled on exactly the edges where pairing shifts.
            if (p_ready && (op_q == OP_READ))
                rsp_data <= {p_o, rsp_data[WIDTH-1:1]};

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        addr_q    <= cmd_addr;
                        data_q    <= cmd_data;
                        bit_cnt   <= '0;
                        wait_cnt  <= '0;
                        cmd_ready <= 1'b0;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        case (cmd_op)
                            OP_WRITE: state <= W_CLR;
                            OP_READ:  state <= R_SEL;
                            OP_RUN:   state <= X_RST;
                            default: begin
                                rsp_err <= 1'b1;
                                state   <= RESP;
                            end
                        endcase
                    end
                end
                W_CLR: begin
                    bit_cnt <= '0;
                    state   <= W_SHIFT;
                end
                W_SHIFT: begin
                    if (bit_cnt == 8'(WIDTH - 1)) begin
                        bit_cnt <= '0;
                        state   <= W_COMMIT;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                W_COMMIT: state <= RESP;
                R_SEL: begin
                    if (wait_cnt == 20'(READ_WAIT - 1)) begin
                        wait_cnt <= '0;
                        state    <= R_CAP;
                    end else begin
                        wait_cnt <= wait_cnt + 20'd1;
                    end
                end
                R_CAP: begin
                    bit_cnt <= '0;
                    state   <= R_SHIFT;
                end
                R_SHIFT: begin
                    if (bit_cnt == 8'(WIDTH - 1)) begin
                        bit_cnt <= '0;
                        state   <= RESP;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                X_RST: begin
                    wait_cnt <= '0;
                    state    <= X_WAIT;
                end
                X_WAIT: begin
                    // While the core reset pulse is still on the wire, any done
                    // is left over from the previous program and is ignored.
                    if (p_done && !p_core_rst) begin
                        state <= RESP;
                    end else if (wait_cnt == 20'(TIMEOUT - 1)) begin
                        rsp_err <= 1'b1;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 20'd1;
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pairing_host_ctrl.sv
// Directed bench for pairing_host_ctrl with a behavioural pairing/memory model.
module tb_pairing_host_ctrl;

    localparam int WIDTH  = 198;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [WIDTH-1:0]  cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_err;
    logic              p_sel, p_w, p_update, p_ready, p_i, p_core_rst;
    logic [ADDR_W-1:0] p_addr;
    logic              p_o;
    logic              p_done = 1'b0;
    logic [3:0]        dbg_state;

    pairing_host_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .p_sel(p_sel), .p_addr(p_addr), .p_w(p_w), .p_update(p_update),
        .p_ready(p_ready), .p_i(p_i), .p_core_rst(p_core_rst),
        .p_o(p_o), .p_done(p_done), .dbg_state(dbg_state)
    );

    // Second instance with a short timeout and done stuck low.
    logic              t_cmd_valid = 1'b0;
    logic              t_cmd_ready;
    logic [1:0]        t_cmd_op = 2'b10;
    logic [ADDR_W-1:0] t_cmd_addr = '0;
    logic [WIDTH-1:0]  t_cmd_data = '0;
    logic              t_rsp_valid;
    logic              t_rsp_ready = 1'b0;
    logic [WIDTH-1:0]  t_rsp_data;
    logic              t_rsp_err;
    logic              t_p_sel, t_p_w, t_p_update, t_p_ready, t_p_i, t_p_core_rst;
    logic [ADDR_W-1:0] t_p_addr;
    logic              t_p_o = 1'b0;
    logic              t_p_done = 1'b0;
    logic [3:0]        t_dbg_state;

    pairing_host_ctrl #(.TIMEOUT(100)) dut_to (
        .clk(clk), .reset(reset),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(t_cmd_op),
        .cmd_addr(t_cmd_addr), .cmd_data(t_cmd_data),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err),
        .p_sel(t_p_sel), .p_addr(t_p_addr), .p_w(t_p_w), .p_update(t_p_update),
        .p_ready(t_p_ready), .p_i(t_p_i), .p_core_rst(t_p_core_rst),
        .p_o(t_p_o), .p_done(t_p_done), .dbg_state(t_dbg_state)
    );

    // Behavioural pairing: shift register, memory, and a done timer.
    logic [WIDTH-1:0] m_sr = '0;
    logic [WIDTH-1:0] m_mem [0:63];
    logic             rd_force = 1'b0;
    logic [WIDTH-1:0] rd_pat = '0;
    int               done_dly = 0;
    int               run_timer = 0;

    assign p_o = m_sr[0];

    always @(posedge clk) begin
        if (p_update)
            m_sr <= p_sel ? (rd_force ? rd_pat : m_mem[p_addr]) : '0;
        else if (p_ready)
            m_sr <= {p_i, m_sr[WIDTH-1:1]};
        if (p_sel && p_w)
            m_mem[p_addr] <= m_sr;
        if (p_core_rst) begin
            run_timer <= done_dly;
            p_done    <= 1'b0;
        end else if (run_timer > 1) begin
            run_timer <= run_timer - 1;
        end else if (run_timer == 1) begin
            run_timer <= 0;
            p_done    <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    int lat, n_upd, n_rdy, n_i1, first_i, n_sel, upd_pos, n_selw, n_crst, n_any;
    logic [ADDR_W-1:0] sel_addr, w_addr;

    function automatic logic [WIDTH-1:0] mk_a5();
        logic [7:0] b;
        logic [WIDTH-1:0] v;
        b = 8'hA5;
        for (int i = 0; i < WIDTH; i++) v[i] = b[3'(i % 8)];
        return v;
    endfunction

    task automatic sample_p();
        if (p_sel) begin
            n_sel++;
            sel_addr = p_addr;
        end
        if (p_update) begin
            n_upd++;
            if (p_sel) upd_pos = n_sel;
        end
        if (p_ready) begin
            n_rdy++;
            if (p_i) begin
                n_i1++;
                if (first_i == 0) first_i = n_rdy;
            end
        end
        if (p_sel && p_w) begin
            n_selw++;
            w_addr = p_addr;
        end
        if (p_core_rst) n_crst++;
        if (p_sel || p_w || p_update || p_ready || p_i || p_core_rst || (p_addr != '0)) n_any++;
    endtask

    // Called at a negedge; the command is accepted on the following posedge.
    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [WIDTH-1:0] data);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_addr  = ~addr;
        cmd_data  = ~data;
    endtask

    // lat = number of posedges from the accept edge until rsp_valid is seen.
    task automatic watch(input int max);
        lat = 0; n_upd = 0; n_rdy = 0; n_i1 = 0; first_i = 0; n_sel = 0;
        upd_pos = 0; n_selw = 0; n_crst = 0; n_any = 0;
        sel_addr = '0; w_addr = '0;
        sample_p();
        while (!rsp_valid && lat < max) begin
            @(negedge clk);
            lat++;
            sample_p();
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_hs got rdy=%b vld=%b err=%b want 1 0 0", cmd_ready, rsp_valid, rsp_err);
        end
        checks++;
        if ({p_sel, p_w, p_update, p_ready, p_i, p_core_rst} !== 6'b0 || p_addr !== '0) begin
            errors++;
            $display("FAIL rst_p got %b addr=%h want all 0",
                     {p_sel, p_w, p_update, p_ready, p_i, p_core_rst}, p_addr);
        end
        checks++;
        if (rsp_data !== '0) begin
            errors++;
            $display("FAIL rst_data got %h want 0", rsp_data);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || dbg_state !== 4'd0) begin
            errors++;
            $display("FAIL rst_idle got rdy=%b st=%0d want 1 0", cmd_ready, dbg_state);
        end
    endtask

    task automatic test_write();
        send(2'b00, 6'h05, 198'h1);
        watch(400);
        checks++;
        if (lat !== 201 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL wr_lat got %0d vld=%b want 201 1", lat, rsp_valid);
        end
        checks++;
        if (n_upd !== 1 || n_rdy !== 198) begin
            errors++;
            $display("FAIL wr_strobes got upd=%0d rdy=%0d want 1 198", n_upd, n_rdy);
        end
        checks++;
        if (n_i1 !== 1 || first_i !== 1) begin
            errors++;
            $display("FAIL wr_bits got ones=%0d first=%0d want 1 1", n_i1, first_i);
        end
        checks++;
        if (n_selw !== 1 || w_addr !== 6'h05) begin
            errors++;
            $display("FAIL wr_commit got n=%0d addr=%h want 1 05", n_selw, w_addr);
        end
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== '0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp got err=%b data=%h rdy=%b want 0 0 0", rsp_err, rsp_data, cmd_ready);
        end
        take_rsp();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_done got rdy=%b vld=%b want 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_read();
        logic [WIDTH-1:0] pat;
        pat = mk_a5();
        rd_pat = pat;
        rd_force = 1'b1;
        send(2'b01, 6'h0A, '0);
        watch(400);
        checks++;
        if (lat !== 202) begin
            errors++;
            $display("FAIL rd_lat got %0d want 202", lat);
        end
        checks++;
        if (n_sel !== 3 || upd_pos !== 3 || n_upd !== 1 || sel_addr !== 6'h0A) begin
            errors++;
            $display("FAIL rd_sel got sel=%0d updpos=%0d upd=%0d addr=%h want 3 3 1 0a",
                     n_sel, upd_pos, n_upd, sel_addr);
        end
        checks++;
        if (n_rdy !== 198 || n_selw !== 0) begin
            errors++;
            $display("FAIL rd_shift got rdy=%0d selw=%0d want 198 0", n_rdy, n_selw);
        end
        checks++;
        if (rsp_data !== pat || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_data got %h err=%b want %h 0", rsp_data, rsp_err, pat);
        end
        take_rsp();
        rd_force = 1'b0;
    endtask

    task automatic test_illegal();
        send(2'b11, 6'h21, {WIDTH{1'b1}});
        watch(10);
        checks++;
        if (lat !== 1 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL ill_rsp got lat=%0d err=%b want 1 1", lat, rsp_err);
        end
        checks++;
        if (rsp_data !== '0 || n_any !== 0) begin
            errors++;
            $display("FAIL ill_quiet got data=%h pcycles=%0d want 0 0", rsp_data, n_any);
        end
        take_rsp();
    endtask

    task automatic test_roundtrip();
        send(2'b00, 6'h03, {WIDTH{1'b1}});
        watch(400);
        take_rsp();
        send(2'b01, 6'h03, '0);
        watch(400);
        checks++;
        if (rsp_data !== {WIDTH{1'b1}} || lat !== 202) begin
            errors++;
            $display("FAIL rt_ones got %h lat=%0d want all ones 202", rsp_data, lat);
        end
        take_rsp();
        send(2'b01, 6'h05, '0);
        watch(400);
        checks++;
        if (rsp_data !== 198'h1) begin
            errors++;
            $display("FAIL rt_order got %h want 1", rsp_data);
        end
        take_rsp();
    endtask

    task automatic test_run();
        done_dly = 500;
        send(2'b10, 6'h00, '0);
        watch(700);
        checks++;
        if (lat < 500 || lat > 510 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_lat got %0d want 500..510", lat);
        end
        checks++;
        if (n_crst !== 1 || n_upd !== 0 || n_rdy !== 0 || n_sel !== 0) begin
            errors++;
            $display("FAIL run_strobes got crst=%0d upd=%0d rdy=%0d sel=%0d want 1 0 0 0",
                     n_crst, n_upd, n_rdy, n_sel);
        end
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL run_rsp got err=%b data=%h want 0 0", rsp_err, rsp_data);
        end
        take_rsp();
        done_dly = 0;
    endtask

    task automatic test_timeout();
        int t_lat;
        int t_crst;
        int t_other;
        t_cmd_op = 2'b10;
        t_cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_cmd_valid = 1'b0;
        t_lat = 0;
        t_crst = 0;
        t_other = 0;
        while (!t_rsp_valid && t_lat < 300) begin
            if (t_p_core_rst) t_crst++;
            if (t_p_sel || t_p_w || t_p_update || t_p_ready || t_p_i || (t_p_addr != '0)) t_other++;
            @(negedge clk);
            t_lat++;
        end
        checks++;
        if (t_lat !== 102 || t_rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL to_rsp got lat=%0d err=%b want 102 1", t_lat, t_rsp_err);
        end
        checks++;
        if (t_crst !== 1 || t_other !== 0 || t_rsp_data !== '0 || t_dbg_state !== 4'd9) begin
            errors++;
            $display("FAIL to_quiet got crst=%0d other=%0d data=%h st=%0d want 1 0 0 9",
                     t_crst, t_other, t_rsp_data, t_dbg_state);
        end
        t_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_rsp_ready = 1'b0;
        checks++;
        if (t_cmd_ready !== 1'b1 || t_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_done got rdy=%b vld=%b want 1 0", t_cmd_ready, t_rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] pat;
        int bad_v, bad_d, bad_r;
        pat = ~mk_a5();
        rd_pat = pat;
        rd_force = 1'b1;
        send(2'b01, 6'h11, '0);
        watch(400);
        bad_v = 0; bad_d = 0; bad_r = 0;
        repeat (50) begin
            if (rsp_valid !== 1'b1) bad_v++;
            if (rsp_data !== pat) bad_d++;
            if (cmd_ready !== 1'b0) bad_r++;
            @(negedge clk);
        end
        checks++;
        if (bad_v !== 0 || bad_d !== 0 || bad_r !== 0) begin
            errors++;
            $display("FAIL bp_hold got badvld=%0d baddata=%0d badrdy=%0d want 0 0 0", bad_v, bad_d, bad_r);
        end
        rd_force = 1'b0;
        // Offer an illegal command during the response handshake itself.
        cmd_op = 2'b11;
        cmd_valid = 1'b1;
        take_rsp();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== 4'd0) begin
            errors++;
            $display("FAIL b2b_idle got rdy=%b vld=%b st=%0d want 1 0 0", cmd_ready, rsp_valid, dbg_state);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        watch(10);
        checks++;
        if (lat !== 1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
            errors++;
            $display("FAIL b2b_next got lat=%0d err=%b data=%h want 1 1 0", lat, rsp_err, rsp_data);
        end
        take_rsp();
    endtask

    task automatic test_reset_mid();
        int saw;
        send(2'b00, 6'h07, mk_a5());
        repeat (60) @(negedge clk);
        checks++;
        if (p_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift got p_ready=%b want 1", p_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({p_sel, p_w, p_update, p_ready, p_i, p_core_rst} !== 6'b0 || p_addr !== '0 ||
            cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort got p=%b addr=%h rdy=%b vld=%b want 0 0 1 0",
                     {p_sel, p_w, p_update, p_ready, p_i, p_core_rst}, p_addr, cmd_ready, rsp_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        saw = 0;
        repeat (250) begin
            @(negedge clk);
            if (rsp_valid) saw++;
        end
        checks++;
        if (saw !== 0) begin
            errors++;
            $display("FAIL mid_norsp got %0d valid cycles want 0", saw);
        end
        send(2'b00, 6'h09, 198'h5);
        watch(400);
        checks++;
        if (lat !== 201 || rsp_err !== 1'b0 || n_rdy !== 198 || n_i1 !== 2 ||
            n_selw !== 1 || w_addr !== 6'h09) begin
            errors++;
            $display("FAIL mid_fresh got lat=%0d err=%b rdy=%0d ones=%0d selw=%0d addr=%h want 201 0 198 2 1 09",
                     lat, rsp_err, n_rdy, n_i1, n_selw, w_addr);
        end
        take_rsp();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_illegal();
        test_roundtrip();
        test_run();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
